struct_array_change_monitor: RTL and testbench

- Parametrised register array of ENTRIES records, each DATA_W bits wide, with value-change detection on every element.
- Each write that actually changes an element's stored value queues a change event: the element index, plus the data in non-coalescing mode.
- Events drain through a valid/ready port, so downstream logic sees per-element change notifications in order, without polling.
- Generalises single-element change detection to N entries, selectable coalescing, and bounded buffering with overflow reporting.

---
 rtl/struct_array_change_monitor.sv | 102 ++++++++++
 tb/tb_struct_array_change_monitor.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/struct_array_change_monitor.sv
// struct_array_change_monitor: register array with per-element change events queued through a valid/ready port
// Ports:
//    clk, rst              rising-edge clock, asynchronous active-high reset
//    wr_en/wr_idx/wr_data  element write (out-of-range index ignored)
//    rd_idx/rd_data        combinational element read
//    chg_valid/chg_ready   change-event handshake, chg_idx/chg_data describe the head event
//    ev_count              events currently queued
//    overflow/clr_ovf      sticky dropped-event flag and its clear
module struct_array_change_monitor #(
   parameter int ENTRIES    = 4,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 8,
   parameter int COALESCE   = 0,
   parameter int IDX_W      = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          wr_en,
   input  logic [IDX_W-1:0]              wr_idx,
   input  logic [DATA_W-1:0]             wr_data,
   input  logic [IDX_W-1:0]              rd_idx,
   output logic [DATA_W-1:0]             rd_data,
   output logic                          chg_valid,
   input  logic                          chg_ready,
   output logic [IDX_W-1:0]              chg_idx,
   output logic [DATA_W-1:0]             chg_data,
   output logic [$clog2(FIFO_DEPTH):0]   ev_count,
   output logic                          overflow,
   input  logic                          clr_ovf
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   logic [DATA_W-1:0] mem_q [ENTRIES];
   logic [DATA_W-1:0] mem_d [ENTRIES];
   logic [IDX_W-1:0]  fq_idx_q [FIFO_DEPTH];
   logic [IDX_W-1:0]  fq_idx_d [FIFO_DEPTH];
   logic [DATA_W-1:0] fq_data_q [FIFO_DEPTH];
   logic [DATA_W-1:0] fq_data_d [FIFO_DEPTH];
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [ENTRIES-1:0] pend_q, pend_d;
   logic              ovf_q, ovf_d;
   logic              wr_ok, changed, pop, full, pend_hit, push;
   logic [IDX_W-1:0]  head_idx;

   always_comb begin
      wr_ok     = wr_en && (int'(wr_idx) < ENTRIES);
      changed   = wr_ok && (wr_data != mem_q[wr_idx]);
      head_idx  = fq_idx_q[rd_ptr_q];
      chg_valid = cnt_q != '0;
      pop       = chg_valid && chg_ready;
      full      = cnt_q == CW'(FIFO_DEPTH);
      // a pending bit being cleared by this cycle's pop no longer blocks a new push
      pend_hit  = (COALESCE != 0) && pend_q[wr_idx] && !(pop && head_idx == wr_idx);
      push      = changed && !pend_hit && (!full || pop);
      mem_d     = mem_q;
      fq_idx_d  = fq_idx_q;
      fq_data_d = fq_data_q;
      pend_d    = pend_q;
      if (wr_ok) mem_d[wr_idx] = wr_data;
      if (push) begin
         fq_idx_d[wr_ptr_q]  = wr_idx;
         fq_data_d[wr_ptr_q] = wr_data;
      end
      if (pop) pend_d[head_idx] = 1'b0;
      if (push && COALESCE != 0) pend_d[wr_idx] = 1'b1;
      wr_ptr_d  = wr_ptr_q + PW'(push);
      rd_ptr_d  = rd_ptr_q + PW'(pop);
      cnt_d     = cnt_q + CW'(push) - CW'(pop);
      ovf_d     = (changed && !pend_hit && !push) ? 1'b1 : clr_ovf ? 1'b0 : ovf_q;
      rd_data   = (int'(rd_idx) < ENTRIES) ? mem_q[rd_idx] : '0;
      chg_idx   = chg_valid ? head_idx : '0;
      chg_data  = !chg_valid ? '0 : (COALESCE != 0) ? mem_q[head_idx] : fq_data_q[rd_ptr_q];
      ev_count  = cnt_q;
      overflow  = ovf_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) mem_q[i] <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fq_idx_q[i]  <= '0;
            fq_data_q[i] <= '0;
         end
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
         pend_q   <= '0;
         ovf_q    <= 1'b0;
      end else begin
         mem_q     <= mem_d;
         fq_idx_q  <= fq_idx_d;
         fq_data_q <= fq_data_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         cnt_q     <= cnt_d;
         pend_q    <= pend_d;
         ovf_q     <= ovf_d;
      end
   end
endmodule

// File: tb/tb_struct_array_change_monitor.sv
// tb_struct_array_change_monitor: checks both coalescing modes against a queue-based reference model
module tb_struct_array_change_monitor;
   logic clk = 0, rst = 0, wr_en = 0, chg_ready = 0, clr_ovf = 0;
   logic [2:0] wr_idx = 0, rd_idx = 0;
   logic [31:0] wr_data = 0;
   logic [31:0] rd0, rd1, d0, d1;
   logic v0, v1, f0, f1;
   logic [2:0] i0, i1;
   logic [3:0] n0, n1;
   logic [40:0] o0, o1;
   int checks = 0, errors = 0;

   typedef struct { logic [2:0] i; logic [31:0] d; } ev_t;
   logic [31:0] mm [5];
   ev_t q0 [$];
   logic [2:0] q1 [$];
   bit pend [5];
   bit ov0, ov1;

   always #5 clk = ~clk;
   assign o0 = {v0, i0, d0, n0, f0};
   assign o1 = {v1, i1, d1, n1, f1};

   struct_array_change_monitor #(.ENTRIES(5), .DATA_W(32), .FIFO_DEPTH(8), .COALESCE(0)) u0 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .rd_idx(rd_idx),
      .rd_data(rd0), .chg_valid(v0), .chg_ready(chg_ready), .chg_idx(i0), .chg_data(d0),
      .ev_count(n0), .overflow(f0), .clr_ovf(clr_ovf));
   struct_array_change_monitor #(.ENTRIES(5), .DATA_W(32), .FIFO_DEPTH(8), .COALESCE(1)) u1 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .rd_idx(rd_idx),
      .rd_data(rd1), .chg_valid(v1), .chg_ready(chg_ready), .chg_idx(i1), .chg_data(d1),
      .ev_count(n1), .overflow(f1), .clr_ovf(clr_ovf));

   function automatic logic [40:0] exp0();
      bit v = q0.size() != 0;
      return {v, v ? q0[0].i : 3'd0, v ? q0[0].d : 32'd0, 4'(q0.size()), ov0};
   endfunction

   function automatic logic [40:0] exp1();
      bit v = q1.size() != 0;
      return {v, v ? q1[0] : 3'd0, v ? mm[q1[0]] : 32'd0, 4'(q1.size()), ov1};
   endfunction

   function automatic logic [31:0] exp_rd();
      return (rd_idx < 5) ? mm[rd_idx] : 32'd0;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 5; k++) begin
         mm[k] = 0;
         pend[k] = 0;
      end
      q0.delete();
      q1.delete();
      ov0 = 0;
      ov1 = 0;
   endtask

   // drive one cycle, advance the model with the pre-edge state, sample 1 time unit after the edge
   task automatic step(input bit we, input logic [2:0] wi, input logic [31:0] wd, input bit rdy, input bit clr);
      bit ch;
      bit drop;
      logic [2:0] h;
      wr_en = we; wr_idx = wi; wr_data = wd; chg_ready = rdy; clr_ovf = clr;
      ch = we && wi < 5 && wd != mm[wi];
      if (rdy && q0.size() != 0) void'(q0.pop_front());
      drop = ch && q0.size() >= 8;
      if (ch && !drop) q0.push_back('{i: wi, d: wd});
      ov0 = drop ? 1'b1 : clr ? 1'b0 : ov0;
      if (rdy && q1.size() != 0) begin
         h = q1.pop_front();
         pend[h] = 0;
      end
      drop = 0;
      if (ch && !pend[wi]) begin
         if (q1.size() < 8) begin
            q1.push_back(wi);
            pend[wi] = 1;
         end else drop = 1;
      end
      ov1 = drop ? 1'b1 : clr ? 1'b0 : ov1;
      if (we && wi < 5) mm[wi] = wd;
      @(posedge clk);
      #1;
      wr_en = 0; chg_ready = 0; clr_ovf = 0;
   endtask

   task automatic test_reset();
      #1 rst = 1;
      #2;
      model_reset();
      checks++; if (o0 !== 41'd0) begin errors++; $display("FAIL reset_u0 got %h exp 0", o0); end
      checks++; if (o1 !== 41'd0) begin errors++; $display("FAIL reset_u1 got %h exp 0", o1); end
      checks++; if (rd0 !== 32'd0) begin errors++; $display("FAIL reset_rd got %h exp 0", rd0); end
      @(negedge clk) rst = 0;
   endtask

   task automatic test_basic();
      rd_idx = 1;
      step(1, 1, 5, 0, 0);
      checks++; if ({v0, i0, d0} !== {1'b1, 3'd1, 32'd5}) begin errors++; $display("FAIL basic_event got %b/%0d/%0d exp 1/1/5", v0, i0, d0); end
      checks++; if (rd0 !== 32'd5) begin errors++; $display("FAIL basic_rd got %0d exp 5", rd0); end
      checks++; if ({v1, i1, d1} !== {1'b1, 3'd1, 32'd5}) begin errors++; $display("FAIL basic_event_c got %b/%0d/%0d exp 1/1/5", v1, i1, d1); end
      step(0, 0, 0, 1, 0);
      checks++; if ({v0, n0, v1, n1} !== 10'd0) begin errors++; $display("FAIL basic_pop got %b %0d %b %0d exp 0 0 0 0", v0, n0, v1, n1); end
   endtask

   task automatic test_equal();
      step(1, 2, 0, 0, 0);
      checks++; if (n0 !== 4'd0 || v0 !== 1'b0) begin errors++; $display("FAIL equal_none got %0d exp 0", n0); end
      step(1, 2, 7, 0, 0);
      step(1, 2, 7, 0, 0);
      checks++; if ({n0, i0, d0} !== {4'd1, 3'd2, 32'd7}) begin errors++; $display("FAIL equal_one got %0d/%0d/%0d exp 1/2/7", n0, i0, d0); end
      checks++; if ({n1, i1, d1} !== {4'd1, 3'd2, 32'd7}) begin errors++; $display("FAIL equal_one_c got %0d/%0d/%0d exp 1/2/7", n1, i1, d1); end
      step(0, 0, 0, 1, 0);
   endtask

   task automatic test_aba();
      logic [31:0] seq [3];
      seq[0] = 1; seq[1] = 2; seq[2] = 1;
      for (int k = 0; k < 3; k++) step(1, 0, seq[k], 0, 0);
      checks++; if (n0 !== 4'd3) begin errors++; $display("FAIL aba_count got %0d exp 3", n0); end
      checks++; if ({n1, i1, d1} !== {4'd1, 3'd0, 32'd1}) begin errors++; $display("FAIL aba_coalesce got %0d/%0d/%0d exp 1/0/1", n1, i1, d1); end
      for (int k = 0; k < 3; k++) begin
         checks++; if ({v0, i0, d0} !== {1'b1, 3'd0, seq[k]}) begin errors++; $display("FAIL aba_order%0d got %b/%0d/%0d exp 1/0/%0d", k, v0, i0, d0, seq[k]); end
         step(0, 0, 0, 1, 0);
      end
   endtask

   task automatic test_overflow();
      int guard;
      rd_idx = 0;
      for (int k = 0; k < 9; k++) step(1, 3'(k % 4), 32'h100 + k, 0, 0);
      checks++; if ({n0, f0} !== {4'd8, 1'b1}) begin errors++; $display("FAIL ovf_full got %0d/%b exp 8/1", n0, f0); end
      checks++; if (rd0 !== 32'h108) begin errors++; $display("FAIL ovf_written got %h exp 108", rd0); end
      checks++; if ({n1, f1} !== {4'd4, 1'b0}) begin errors++; $display("FAIL ovf_coalesce got %0d/%b exp 4/0", n1, f1); end
      step(0, 0, 0, 0, 1);
      checks++; if (f0 !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", f0); end
      step(1, 0, 32'h200, 0, 1);
      checks++; if (f0 !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got %b exp 1", f0); end
      step(0, 0, 0, 0, 1);
      step(1, 1, 32'h300, 1, 0);
      checks++; if ({n0, f0} !== {4'd8, 1'b0}) begin errors++; $display("FAIL ovf_push_pop got %0d/%b exp 8/0", n0, f0); end
      guard = 0;
      while ((v0 || v1) && guard < 20) begin
         step(0, 0, 0, 1, 0);
         guard++;
      end
      checks++; if ({n0, n1} !== 8'd0) begin errors++; $display("FAIL ovf_drain got %0d/%0d exp 0/0", n0, n1); end
   endtask

   task automatic test_pop_push_same();
      step(1, 3, 32'h55, 0, 0);
      step(1, 3, 9, 1, 0);
      checks++; if ({v1, i1, d1, n1} !== {1'b1, 3'd3, 32'd9, 4'd1}) begin errors++; $display("FAIL popush_c got %b/%0d/%0d/%0d exp 1/3/9/1", v1, i1, d1, n1); end
      checks++; if ({v0, i0, d0, n0} !== {1'b1, 3'd3, 32'd9, 4'd1}) begin errors++; $display("FAIL popush got %b/%0d/%0d/%0d exp 1/3/9/1", v0, i0, d0, n0); end
      step(1, 3, 10, 0, 0);
      checks++; if ({n1, d1} !== {4'd1, 32'd10}) begin errors++; $display("FAIL pending_live got %0d/%0d exp 1/10", n1, d1); end
      checks++; if ({n0, d0} !== {4'd2, 32'd9}) begin errors++; $display("FAIL pending_nc got %0d/%0d exp 2/9", n0, d0); end
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0);
   endtask

   task automatic test_midreset();
      rd_idx = 0;
      for (int k = 0; k < 5; k++) step(1, 3'(k), 32'h40 + k, 0, 0);
      checks++; if (n0 !== 4'd5) begin errors++; $display("FAIL mid_pre got %0d exp 5", n0); end
      rst = 1;
      #2;
      model_reset();
      checks++; if ({o0, o1, rd0} !== '0) begin errors++; $display("FAIL mid_async got %h %h %h exp 0", o0, o1, rd0); end
      @(negedge clk) rst = 0;
      step(1, 0, 0, 0, 0);
      checks++; if ({v0, n0, v1, n1} !== 10'd0) begin errors++; $display("FAIL mid_eq got %0d/%0d exp 0/0", n0, n1); end
   endtask

   task automatic test_random();
      for (int k = 0; k < 600; k++) begin
         rd_idx = 3'($urandom % 8);
         step(($urandom % 4) != 0, 3'($urandom % 8), $urandom % 4, ($urandom % 3) == 0, ($urandom % 16) == 0);
         checks++; if (o0 !== exp0()) begin errors++; $display("FAIL rand_u0 cyc %0d got %h exp %h", k, o0, exp0()); end
         checks++; if (o1 !== exp1()) begin errors++; $display("FAIL rand_u1 cyc %0d got %h exp %h", k, o1, exp1()); end
         checks++; if (rd0 !== exp_rd() || rd1 !== exp_rd()) begin errors++; $display("FAIL rand_rd cyc %0d got %h/%h exp %h", k, rd0, rd1, exp_rd()); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_equal();
      test_aba();
      test_overflow();
      test_pop_push_same();
      test_midreset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
